data_port_arbiter: RTL and testbench

- Shares port B of the data memory (mem_async) between two requesters: requester 0 is uart_controller (debug read/write), requester 1 is a future peripheral/DMA master.
- Round-robin arbitration with a per-cycle req/ack handshake and a read-return pipeline, so reads issue back-to-back.
- Sits between the requesters and the mem_async instance in test_asm18; the processor keeps port A exclusively.

---
 rtl/asm18_pkg.sv | 12 +
 rtl/rr_arbiter2.sv | 36 +++
 rtl/data_port_arbiter.sv | 105 ++++++++++
 tb/tb_data_port_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/asm18_pkg.sv
// Shared definitions for the asm18 data-memory port B sharing logic.
// Word width and the requester id type used by the arbiter and its pipeline.
package asm18_pkg;

  localparam int WORD_SIZE = 18;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant with a priority register; grant is combinational.
// No backpressure: a request is granted the cycle it wins, losers wait and hold.
module rr_arbiter2
  import asm18_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic       gnt_vld,
  output req_id_t    gnt_id
);

  req_id_t prio;

  // Grant is gated by reset so nothing is acknowledged while reset is held.
  always_comb begin
    gnt_vld = reset_n & (|req);
    gnt_id  = REQ0;
    unique case (req)
      2'b01:   gnt_id = REQ0;
      2'b10:   gnt_id = REQ1;
      2'b11:   gnt_id = prio;
      default: gnt_id = REQ0;
    endcase
  end

  // After any grant the other requester wins the next tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio <= REQ0;
    end else if (gnt_vld) begin
      prio <= ~gnt_id;
    end
  end

endmodule

// File: rtl/data_port_arbiter.sv
// Shares mem_async port B between two requesters with round-robin req/ack arbitration.
// Ack same cycle as grant, read data READ_LATENCY cycles after ack; losers hold req until ack.
module data_port_arbiter
  import asm18_pkg::*;
#(
  parameter int ADDR_SIZE    = 18,
  parameter int WORD_SIZE    = asm18_pkg::WORD_SIZE,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,

  input  logic                 r0_req,
  input  logic                 r0_we,
  input  logic [ADDR_SIZE-1:0] r0_addr,
  input  logic [WORD_SIZE-1:0] r0_wdata,
  output logic                 r0_ack,
  output logic                 r0_rvalid,
  output logic [WORD_SIZE-1:0] r0_rdata,

  input  logic                 r1_req,
  input  logic                 r1_we,
  input  logic [ADDR_SIZE-1:0] r1_addr,
  input  logic [WORD_SIZE-1:0] r1_wdata,
  output logic                 r1_ack,
  output logic                 r1_rvalid,
  output logic [WORD_SIZE-1:0] r1_rdata,

  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_wren,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  logic                 gnt_vld;
  req_id_t              gnt_id;
  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [WORD_SIZE-1:0] sel_wdata;
  logic [ADDR_SIZE-1:0] last_addr;
  logic [WORD_SIZE-1:0] last_wdata;

  logic [READ_LATENCY-1:0] tag_v;
  req_id_t                 tag_id [READ_LATENCY];

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({r1_req, r0_req}),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign r0_ack = gnt_vld && (gnt_id == REQ0);
  assign r1_ack = gnt_vld && (gnt_id == REQ1);

  always_comb begin
    sel_we    = r0_we;
    sel_addr  = r0_addr;
    sel_wdata = r0_wdata;
    if (gnt_id == REQ1) begin
      sel_we    = r1_we;
      sel_addr  = r1_addr;
      sel_wdata = r1_wdata;
    end
  end

  // Address/data bus keeps the last granted values while idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_addr  <= '0;
      last_wdata <= '0;
    end else if (gnt_vld) begin
      last_addr  <= sel_addr;
      last_wdata <= sel_wdata;
    end
  end

  assign mem_addr  = gnt_vld ? sel_addr  : last_addr;
  assign mem_wdata = gnt_vld ? sel_wdata : last_wdata;
  assign mem_wren  = gnt_vld & sel_we;

  // Read tags travel alongside the memory latency so returning data finds its owner.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_id[i] <= REQ0;
      end
    end else begin
      tag_v[0]  <= gnt_vld & ~sel_we;
      tag_id[0] <= gnt_id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign r0_rvalid = reset_n & tag_v[READ_LATENCY-1] & (tag_id[READ_LATENCY-1] == REQ0);
  assign r1_rvalid = reset_n & tag_v[READ_LATENCY-1] & (tag_id[READ_LATENCY-1] == REQ1);
  assign r0_rdata  = mem_rdata;
  assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed bench for data_port_arbiter: one instance at READ_LATENCY=1 and one at 3,
// each driving its own behavioural memory, both fed the same requester stimulus.
module tb_data_port_arbiter;
  import asm18_pkg::*;

  localparam int AW = 18;
  localparam int DW = 18;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;

  logic          a_r0_ack, a_r0_rvalid, a_r1_ack, a_r1_rvalid, a_mem_wren;
  logic [DW-1:0] a_r0_rdata, a_r1_rdata, a_mem_wdata, a_mem_rdata;
  logic [AW-1:0] a_mem_addr;

  logic          b_r0_ack, b_r0_rvalid, b_r1_ack, b_r1_rvalid, b_mem_wren;
  logic [DW-1:0] b_r0_rdata, b_r1_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0] b_mem_addr;

  int errors = 0;
  int checks = 0;

  data_port_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .READ_LATENCY(1)) u_dut_rl1 (
    .clock(clock), .reset_n(reset_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(a_r0_ack), .r0_rvalid(a_r0_rvalid), .r0_rdata(a_r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(a_r1_ack), .r1_rvalid(a_r1_rvalid), .r1_rdata(a_r1_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wren(a_mem_wren),
    .mem_rdata(a_mem_rdata)
  );

  data_port_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .READ_LATENCY(3)) u_dut_rl3 (
    .clock(clock), .reset_n(reset_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(b_r0_ack), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(b_r1_ack), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wren(b_mem_wren),
    .mem_rdata(b_mem_rdata)
  );

  // Memories preload addr+0x1000 while reset is low; writes land at the edge.
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [1024];
  logic [DW-1:0] b_q0, b_q1;

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= DW'(i + 'h1000);
    end else if (a_mem_wren) begin
      mem_a[a_mem_addr[9:0]] <= a_mem_wdata;
    end
    a_mem_rdata <= mem_a[a_mem_addr[9:0]];
  end

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= DW'(i + 'h1000);
    end else if (b_mem_wren) begin
      mem_b[b_mem_addr[9:0]] <= b_mem_wdata;
    end
    b_q0        <= mem_b[b_mem_addr[9:0]];
    b_q1        <= b_q0;
    b_mem_rdata <= b_q1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int own [8];
  int adr [8];
  int i0, i1;

  initial begin
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    reset_n = 0;
    tick();
    tick();

    // Requests during reset must not be acknowledged or write.
    r0_req = 1; r0_we = 1; r0_addr = 18'h00055;
    @(negedge clock);
    chk("rst_ack", 32'({a_r1_ack, a_r0_ack, b_r1_ack, b_r0_ack}), 0);
    chk("rst_wren", 32'({a_mem_wren, b_mem_wren}), 0);
    chk("rst_addr", 32'(a_mem_addr), 0);
    tick();
    r0_req = 0; r0_we = 0; r0_addr = '0;
    reset_n = 1;

    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("idle_out", 32'({a_r0_ack, a_r1_ack, a_r0_rvalid, a_r1_rvalid, a_mem_wren,
                            b_r0_ack, b_r1_ack, b_r0_rvalid, b_r1_rvalid, b_mem_wren}), 0);
      chk("idle_addr", 32'(a_mem_addr), 0);
      tick();
    end

    // r0 write then read back of the same word.
    r0_req = 1; r0_we = 1; r0_addr = 18'h00010; r0_wdata = 18'h2ABCD;
    @(negedge clock);
    chk("wr_ack", 32'({a_r1_ack, a_r0_ack}), 1);
    chk("wr_wren", 32'(a_mem_wren), 1);
    chk("wr_addr", 32'(a_mem_addr), 'h10);
    chk("wr_data", 32'(a_mem_wdata), 'h2ABCD);
    tick();
    r0_we = 0;
    @(negedge clock);
    chk("rd_ack", 32'({a_r1_ack, a_r0_ack}), 1);
    chk("rd_wren", 32'(a_mem_wren), 0);
    chk("wr_no_rvalid", 32'({a_r1_rvalid, a_r0_rvalid}), 0);
    tick();
    r0_req = 0;
    @(negedge clock);
    chk("rd_rvalid", 32'({a_r1_rvalid, a_r0_rvalid}), 1);
    chk("rd_rdata", 32'(a_r0_rdata), 'h2ABCD);
    chk("idle_ack", 32'({a_r1_ack, a_r0_ack}), 0);
    chk("hold_addr", 32'(a_mem_addr), 'h10);
    chk("hold_wdata", 32'(a_mem_wdata), 'h2ABCD);
    chk("idle_wren", 32'(a_mem_wren), 0);
    tick();
    @(negedge clock);
    chk("rd_rvalid_once", 32'({a_r1_rvalid, a_r0_rvalid}), 0);
    tick();

    // r1 streams four writes then four reads back-to-back.
    for (int i = 0; i < 4; i++) begin
      r1_req = 1; r1_we = 1; r1_addr = AW'(i); r1_wdata = DW'('h25A50 + i);
      @(negedge clock);
      chk("s_wr_ack", 32'({a_r1_ack, a_r0_ack}), 2);
      chk("s_wr_wren", 32'(a_mem_wren), 1);
      chk("s_wr_addr", 32'(a_mem_addr), i);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      r1_we = 0; r1_addr = AW'(i);
      @(negedge clock);
      chk("s_rd_ack", 32'({a_r1_ack, a_r0_ack}), 2);
      if (i == 0) begin
        chk("s_rd_rv_first", 32'({a_r1_rvalid, a_r0_rvalid}), 0);
      end else begin
        chk("s_rd_rv", 32'({a_r1_rvalid, a_r0_rvalid}), 2);
        chk("s_rd_data", 32'(a_r1_rdata), 'h25A50 + i - 1);
      end
      tick();
    end
    r1_req = 0;
    @(negedge clock);
    chk("s_rd_rv_last", 32'({a_r1_rvalid, a_r0_rvalid}), 2);
    chk("s_rd_data_last", 32'(a_r1_rdata), 'h25A53);
    tick();
    @(negedge clock);
    chk("s_rd_rv_done", 32'({a_r1_rvalid, a_r0_rvalid}), 0);
    tick();

    // Continuous contention: acks alternate starting with r0; data follows its owner.
    i0 = 0; i1 = 0;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        r0_req = 1; r1_req = 1; r0_we = 0; r1_we = 0;
        r0_addr = AW'('h100 + i0);
        r1_addr = AW'('h200 + i1);
      end else begin
        r0_req = 0; r1_req = 0;
      end
      @(negedge clock);
      if (k < 8) begin
        own[k] = k % 2;
        adr[k] = (k % 2 == 0) ? ('h100 + i0) : ('h200 + i1);
        chk("cnt_ack", 32'({a_r1_ack, a_r0_ack}), (k % 2 == 0) ? 1 : 2);
        chk("cnt_ack_rl3", 32'({b_r1_ack, b_r0_ack}), (k % 2 == 0) ? 1 : 2);
      end
      if (k >= 1) begin
        if (k - 1 < 8) begin
          chk("cnt_rv", 32'({a_r1_rvalid, a_r0_rvalid}), (own[k-1] == 0) ? 1 : 2);
          chk("cnt_data", 32'((own[k-1] == 0) ? a_r0_rdata : a_r1_rdata), adr[k-1] + 'h1000);
        end else begin
          chk("cnt_rv_end", 32'({a_r1_rvalid, a_r0_rvalid}), 0);
        end
      end
      if (k >= 3) begin
        if (k - 3 < 8) begin
          chk("rl3_rv", 32'({b_r1_rvalid, b_r0_rvalid}), (own[k-3] == 0) ? 1 : 2);
          chk("rl3_data", 32'((own[k-3] == 0) ? b_r0_rdata : b_r1_rdata), adr[k-3] + 'h1000);
        end else begin
          chk("rl3_rv_end", 32'({b_r1_rvalid, b_r0_rvalid}), 0);
        end
      end
      tick();
      if (k < 8) begin
        if (k % 2 == 0) i0++;
        else i1++;
      end
    end

    // Reset right after an r0 read ack drops the read and restores prio.
    r0_req = 1; r0_we = 0; r0_addr = 18'h00010; r1_req = 0;
    @(negedge clock);
    chk("pre_rst_ack", 32'({a_r1_ack, a_r0_ack}), 1);
    tick();
    reset_n = 0; r0_req = 0;
    @(negedge clock);
    chk("mid_rst_rv", 32'({a_r0_rvalid, a_r1_rvalid, b_r0_rvalid, b_r1_rvalid}), 0);
    chk("mid_rst_addr", 32'(a_mem_addr), 0);
    chk("mid_rst_wdata", 32'(a_mem_wdata), 0);
    tick();
    tick();
    reset_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("post_rst_rv", 32'({a_r0_rvalid, a_r1_rvalid, b_r0_rvalid, b_r1_rvalid}), 0);
      tick();
    end
    r0_req = 1; r1_req = 1; r0_we = 0; r1_we = 0;
    r0_addr = 18'h00104; r1_addr = 18'h00204;
    @(negedge clock);
    chk("prio_rst", 32'({a_r1_ack, a_r0_ack}), 1);
    chk("prio_rst_rl3", 32'({b_r1_ack, b_r0_ack}), 1);
    tick();
    r0_req = 0;
    @(negedge clock);
    chk("prio_next", 32'({a_r1_ack, a_r0_ack}), 2);
    chk("post_rv0", 32'({a_r1_rvalid, a_r0_rvalid}), 1);
    chk("post_data0", 32'(a_r0_rdata), 'h1104);
    tick();
    r1_req = 0;
    @(negedge clock);
    chk("post_rv1", 32'({a_r1_rvalid, a_r0_rvalid}), 2);
    chk("post_data1", 32'(a_r1_rdata), 'h1204);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
